// File: rtl/mult_result_collector_if.sv
// -----------------------------------------------------------------------------
// mult_result_collector_if
// Bundles the product-capture and downstream handshake signals of
// mult_result_collector.
//   slave  : the collector itself (receives products, serves the consumer)
//   master : the environment (upstream product stage + downstream consumer)
// Signals:
//   FinalProductin / in_valid / in_ready : upstream product capture
//   out_data / out_valid / out_ready     : downstream valid/ready handshake
//   count                                : buffer occupancy, 0..DEPTH
//   overflow                             : sticky "a valid product was dropped"
// -----------------------------------------------------------------------------
interface mult_result_collector_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  logic [WIDTH-1:0]         FinalProductin;
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;

  modport slave (
    input  FinalProductin,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready,
    output count,
    output overflow
  );

  modport master (
    output FinalProductin,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  count,
    input  overflow
  );
endinterface

// File: rtl/mult_result_collector.sv
// -----------------------------------------------------------------------------
// mult_result_collector
// Receiving end of the final-product register stage. Every product flagged
// valid is written into a DEPTH-entry first-word-fall-through FIFO and offered
// to the downstream consumer over a valid/ready handshake. The upstream
// pipeline never stalls, so a product arriving while the buffer is full is
// dropped and the sticky overflow flag is raised.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   io    : mult_result_collector_if.slave (product in, handshake out,
//           occupancy count, overflow flag)
// DEPTH must be a power of two (>= 2) so the pointers wrap by overflowing.
// -----------------------------------------------------------------------------
module mult_result_collector #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  mult_result_collector_if.slave  io
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [PW-1:0] PTR_ONE    = PW'(1);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam logic [CW-1:0] COUNT_ZERO = CW'(0);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             overflow_r;

  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  logic             drop_s;
  logic [CW-1:0]    count_nxt_s;

  // Handshake qualification. Full/empty come only from the registered count,
  // so a pop in the same cycle never makes room for an incoming product.
  always_comb begin
    full_s  = (count_r == COUNT_FULL);
    empty_s = (count_r == COUNT_ZERO);
    push_s  = io.in_valid & ~full_s;
    pop_s   = io.out_ready & ~empty_s;
    drop_s  = io.in_valid & full_s;
  end

  // Occupancy next-state: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + COUNT_ONE;
      2'b01:   count_nxt_s = count_r - COUNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= COUNT_ZERO;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Storage array; contents are don't-care after reset, so it has no reset.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= io.FinalProductin;
    end
  end

  // Outputs derive only from registered state. out_data is forced to zero
  // while empty so stale storage never leaks, including straight after reset.
  assign io.in_ready  = ~full_s;
  assign io.out_valid = ~empty_s;
  assign io.out_data  = empty_s ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
  assign io.count     = count_r;
  assign io.overflow  = overflow_r;

endmodule

// File: tb/tb_mult_result_collector.sv
// -----------------------------------------------------------------------------
// tb_mult_result_collector
// Directed bench for mult_result_collector (WIDTH=32, DEPTH=4): reset checks,
// a streaming sequence, a table of single-cycle vectors with hand-computed
// expectations, and an asynchronous mid-stream reset sequence.
// -----------------------------------------------------------------------------
module tb_mult_result_collector;

  logic clock;
  logic reset;

  mult_result_collector_if #(.WIDTH(32), .DEPTH(4)) bus ();

  mult_result_collector #(.WIDTH(32), .DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .io    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        iv;
    logic [31:0] din;
    logic        ordy;
    logic        e_ov;
    logic [31:0] e_data;
    logic [2:0]  e_cnt;
    logic        e_ir;
    logic        e_ovf;
  } vec_t;

  vec_t tbl [17];
  int   vec_n  = 0;
  int   miss_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_n++;
    if (act !== exp) begin
      miss_n++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic ov, input logic [31:0] data,
                         input logic [2:0] cnt, input logic ir, input logic ovf);
    chk({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, ov});
    chk({tag, ".out_data"},  bus.out_data,            data);
    chk({tag, ".count"},     {29'd0, bus.count},      {29'd0, cnt});
    chk({tag, ".in_ready"},  {31'd0, bus.in_ready},   {31'd0, ir});
    chk({tag, ".overflow"},  {31'd0, bus.overflow},   {31'd0, ovf});
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Single pass
    tbl[0]  = '{1'b1, 32'h3F800000, 1'b1, 1'b1, 32'h3F800000, 3'd1, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 3'd0, 1'b1, 1'b0};
    // Empty with out_ready: nothing happens
    tbl[2]  = '{1'b0, 32'h12345678, 1'b1, 1'b0, 32'h00000000, 3'd0, 1'b1, 1'b0};
    // Fill with out_ready low
    tbl[3]  = '{1'b1, 32'h11111111, 1'b0, 1'b1, 32'h11111111, 3'd1, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 32'h22222222, 1'b0, 1'b1, 32'h11111111, 3'd2, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 32'h33333333, 1'b0, 1'b1, 32'h11111111, 3'd3, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 32'h44444444, 1'b0, 1'b1, 32'h11111111, 3'd4, 1'b0, 1'b0};
    // Full + push + pop: DEADBEEF dropped, head popped, overflow sets
    tbl[7]  = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 32'h22222222, 3'd3, 1'b1, 1'b1};
    // Drain in order, overflow sticky
    tbl[8]  = '{1'b0, 32'h00000000, 1'b1, 1'b1, 32'h33333333, 3'd2, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 32'h00000000, 1'b1, 1'b1, 32'h44444444, 3'd1, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 3'd0, 1'b1, 1'b1};
    // Push+pop at count=1 replaces head
    tbl[11] = '{1'b1, 32'hAAAAAAAA, 1'b0, 1'b1, 32'hAAAAAAAA, 3'd1, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 32'hBBBBBBBB, 1'b1, 1'b1, 32'hBBBBBBBB, 3'd1, 1'b1, 1'b1};
    tbl[13] = '{1'b1, 32'hCCCCCCCC, 1'b0, 1'b1, 32'hBBBBBBBB, 3'd2, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 32'hCCCCCCCC, 3'd1, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 3'd0, 1'b1, 1'b1};
    // Data ignored without in_valid
    tbl[16] = '{1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000000, 3'd0, 1'b1, 1'b1};

    // Reset held with traffic on the inputs
    reset                 = 1'b0;
    bus.in_valid          = 1'b1;
    bus.out_ready         = 1'b1;
    bus.FinalProductin    = 32'hCAFEF00D;
    #1;
    chk_all("reset_t0", 1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("reset_hold", 1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
    end
    bus.in_valid = 1'b0;
    reset        = 1'b1;

    // Continuous streaming: each word visible one edge after its push, popped next
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      bus.in_valid       = 1'b1;
      bus.FinalProductin = 32'(i);
      step();
      chk_all("stream", 1'b1, 32'(i), 3'd1, 1'b1, 1'b0);
    end
    bus.in_valid = 1'b0;
    step();
    chk_all("stream_end", 1'b0, 32'h0, 3'd0, 1'b1, 1'b0);

    // Table-driven vectors
    for (int i = 0; i < 17; i++) begin
      bus.in_valid       = tbl[i].iv;
      bus.FinalProductin = tbl[i].din;
      bus.out_ready      = tbl[i].ordy;
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].e_ov, tbl[i].e_data, tbl[i].e_cnt,
              tbl[i].e_ir, tbl[i].e_ovf);
    end

    // Asynchronous reset mid-stream with count=3
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid       = 1'b1;
      bus.FinalProductin = 32'h70000000 + 32'(i);
      step();
    end
    bus.in_valid = 1'b0;
    chk_all("pre_async", 1'b1, 32'h70000000, 3'd3, 1'b1, 1'b1);
    #3;
    reset = 1'b0;   // between edges
    #1;
    chk_all("async_rst", 1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
    #3;
    reset = 1'b1;
    bus.in_valid       = 1'b1;
    bus.FinalProductin = 32'h55555555;
    step();
    bus.in_valid = 1'b0;
    chk_all("post_rst", 1'b1, 32'h55555555, 3'd1, 1'b1, 1'b0);
    bus.out_ready = 1'b1;
    step();
    chk_all("post_rst_pop", 1'b0, 32'h0, 3'd0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end

endmodule
